arb_rr_4x2: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource among four clients and presents the winner both as a one-hot grant and as a 2-bit encoded index, i.e. the 4-to-2 encoding of the grant vector. It sits in front of the shared datapath and sequences access with a request/grant/release handshake. An optional watchdog forcibly reclaims a grant that is held too long.

---
 rtl/arb_rr_4x2_if.sv | 21 ++
 rtl/arb_rr_4x2.sv | 139 +++++++++++++
 tb/tb_arb_rr_4x2.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/arb_rr_4x2_if.sv
// Request/grant/release bundle between the four clients and the round-robin arbiter.
// The arbiter uses the slave modport; the client side uses master.
interface arb_rr_4x2_if;
  logic       en;
  logic [3:0] req;
  logic       release_i;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  modport master (
    output en, req, release_i,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  en, req, release_i,
    output gnt, gnt_idx, gnt_vld, timeout
  );
endinterface

// File: rtl/arb_rr_4x2.sv
// Four-client round-robin arbiter with one-hot and encoded registered grant outputs.
// Optional grant watchdog is built when ARB_TIMEOUT_EN is defined.
module arb_rr_4x2 #(
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         rst_n,
  arb_rr_4x2_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       owner_rel;
  logic       expire;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("arb_rr_4x2: MAX_HOLD must be in 2..256");
  end

  // First requesting client at or after the priority pointer, wrapping mod 4.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + i[1:0];
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign owner_rel = bus.release_i | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  assign expire = (state_q == BUSY) && (cnt_q == CW'(MAX_HOLD - 1));

  // Normal release wins over expiry, so the pulse only flags a true forced reclaim.
  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (state_q == BUSY && !owner_rel) begin
      if (expire) begin
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (bus.en && found) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << winner;
          idx_d   = winner;
          vld_d   = 1'b1;
        end
      end
      BUSY: begin
        if (owner_rel || expire) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          idx_d   = 2'b00;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        idx_d   = 2'b00;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'b00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;

  a_onehot_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    vld_q |-> (gnt_q == (4'b0001 << idx_q)));
  a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !vld_q |-> (gnt_q == 4'b0000 && idx_q == 2'b00));

endmodule

// File: tb/tb_arb_rr_4x2.sv
// Scoreboard bench for arb_rr_4x2: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares them against the arbiter.
module tb_arb_rr_4x2;

  localparam int MAX_HOLD = 4;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       tmo;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  exp_t exp_q[$];

  int owner = -1;
  int ptr   = 0;
  int hold  = 0;
  bit tmo   = 1'b0;

  arb_rr_4x2_if bus ();

  arb_rr_4x2 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: owner is the client holding the grant (-1 when free), hold counts its cycles.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      owner = -1;
      ptr   = 0;
      hold  = 0;
      tmo   = 1'b0;
      exp_q.delete();
    end else begin
      tmo = 1'b0;
      if (owner < 0) begin
        if (bus.en) begin
          for (int i = 0; i < 4; i++) begin
            if (owner < 0 && bus.req[(ptr + i) % 4]) begin
              owner = (ptr + i) % 4;
              hold  = 1;
            end
          end
        end
      end else if (bus.release_i || !bus.req[owner]) begin
        ptr   = (owner + 1) % 4;
        owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (hold == MAX_HOLD) begin
        ptr   = (owner + 1) % 4;
        owner = -1;
        tmo   = 1'b1;
      end
`endif
      else begin
        hold++;
      end
    end
    e.vld = (owner >= 0);
    e.gnt = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
    e.idx = (owner >= 0) ? 2'(owner) : 2'b00;
    e.tmo = tmo;
    exp_q.push_back(e);
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("gnt", bus.gnt, e.gnt);
      checkOutput("gnt_idx", {2'b00, bus.gnt_idx}, {2'b00, e.idx});
      checkOutput("gnt_vld", {3'b000, bus.gnt_vld}, {3'b000, e.vld});
      checkOutput("timeout", {3'b000, bus.timeout}, {3'b000, e.tmo});
    end
  end

  task automatic applyStimulus(input logic e, input logic [3:0] r, input logic rl, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.en        = e;
      bus.req       = r;
      bus.release_i = rl;
    end
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.req       = 4'b0000;
    bus.release_i = 1'b0;

    applyStimulus(1'b0, 4'b0000, 1'b0, 3);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Move the pointer off zero, then reset in the middle of client 1's grant.
    applyStimulus(1'b1, 4'b1111, 1'b1, 3);
    applyStimulus(1'b1, 4'b1111, 1'b0, 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 4'b1111, 1'b0, 2);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3);

    // Single requester with a delayed release, then continuous round robin.
    applyStimulus(1'b1, 4'b0100, 1'b0, 3);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 2);
    applyStimulus(1'b1, 4'b1111, 1'b1, 12);
    applyStimulus(1'b0, 4'b0000, 1'b0, 2);

    // Owner drop hands over to the next client; en low keeps a held grant but blocks new ones.
    applyStimulus(1'b1, 4'b0010, 1'b0, 3);
    applyStimulus(1'b1, 4'b0100, 1'b0, 3);
    applyStimulus(1'b0, 4'b0100, 1'b0, 3);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4);

    // Single client holding without release: watchdog reclaims, otherwise held indefinitely.
    applyStimulus(1'b1, 4'b0001, 1'b0, 100);
    applyStimulus(1'b1, 4'b0000, 1'b0, 2);
    applyStimulus(1'b1, 4'b0001, 1'b0, MAX_HOLD);
    applyStimulus(1'b1, 4'b0001, 1'b1, 1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 2);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus.en        = ($urandom % 8) != 0;
      bus.req       = 4'($urandom);
      bus.release_i = ($urandom % 5) == 0;
      if (($urandom % 300) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end

    applyStimulus(1'b0, 4'b0000, 1'b0, 3);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
